// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - halfword-to-word instruction prefetch queue
module prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                bus,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [AW-1:0]              fetch_address,
  input  logic                       flush,
  input  logic [AW-1:0]              flush_addr,
  output logic [31:0]                ir,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [15:0]         hold_q, hold_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       fetch_q, fetch_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];

  logic xfer;
  logic push;
  logic pop;

  // Only a high half can complete a word, so a full queue stalls only in HIGH.
  assign wr_ready      = !(state_q == HIGH && count_q == CW'(DEPTH));
  assign ir_valid      = (count_q != '0);
  assign ir            = ir_valid ? mem_q[head_q] : 32'h0000_0000;
  assign count         = count_q;
  assign fetch_address = fetch_q;

  assign xfer = wr_valid && wr_ready;
  assign push = xfer && (state_q == HIGH);
  assign pop  = ir_valid && ir_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    fetch_d = fetch_q;
    mem_d   = mem_q;

    if (flush) begin
      state_d = LOW;
      hold_d  = 16'h0000;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fetch_d = flush_addr;
    end else begin
      if (xfer) begin
        fetch_d = fetch_q + AW'(1);
        if (state_q == LOW) begin
          hold_d  = bus;
          state_d = HIGH;
        end else begin
          state_d        = LOW;
          mem_d[tail_q]  = {bus, hold_q};
          tail_d         = tail_q + PW'(1);
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOW;
      hold_q  <= 16'h0000;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fetch_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fetch_q <= fetch_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed-vector bench for prefetch_queue
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic [15:0] bus;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] fetch_address;
  logic        flush;
  logic [15:0] flush_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [2:0]  count;

  int n_vec;
  int n_bad;

  prefetch_queue #(.DEPTH(4), .AW(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .fetch_address (fetch_address),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .count         (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] h);
    wr_valid = 1'b1;
    bus      = h;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic pop_one();
    ir_ready = 1'b1;
    @(posedge clk);
    #1;
    ir_ready = 1'b0;
  endtask

  logic [31:0] exp_drain [4];
  logic [31:0] got_q [$];

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    bus = 16'h0;
    wr_valid = 1'b0;
    flush = 1'b0;
    flush_addr = 16'h0;
    ir_ready = 1'b0;

    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_fetch", 32'(fetch_address), 32'd0);
    check("rst_ir", ir, 32'h0);
    reset = 1'b1;

    // first word: low then high, visible the cycle after the high half
    xfer(16'h1234);
    check("w1_count", 32'(count), 32'd0);
    check("w1_ir_valid", 32'(ir_valid), 32'd0);
    check("w1_fetch", 32'(fetch_address), 32'h0001);
    xfer(16'hABCD);
    check("w2_ir", ir, 32'hABCD_1234);
    check("w2_ir_valid", 32'(ir_valid), 32'd1);
    check("w2_fetch", 32'(fetch_address), 32'h0002);
    check("w2_count", 32'(count), 32'd1);
    pop_one();
    check("pop_count", 32'(count), 32'd0);

    // fill to DEPTH plus one extra low halfword
    for (int i = 0; i < 4; i++) begin
      xfer(16'h1000 + 16'(i));
      xfer(16'h2000 + 16'(i));
    end
    check("full_count", 32'(count), 32'd4);
    check("full_low_ready", 32'(wr_ready), 32'd1);
    xfer(16'h3333);
    check("full_hi_ready", 32'(wr_ready), 32'd0);
    check("full_fetch", 32'(fetch_address), 32'h000B);
    check("full_head", ir, 32'h2000_1000);
    wr_valid = 1'b1;
    bus = 16'h4444;
    ir_ready = 1'b1;
    @(posedge clk);
    #1;
    ir_ready = 1'b0;
    check("stall_count", 32'(count), 32'd3);
    check("stall_ready", 32'(wr_ready), 32'd1);
    check("stall_fetch", 32'(fetch_address), 32'h000B);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("refill_count", 32'(count), 32'd4);
    check("refill_fetch", 32'(fetch_address), 32'h000C);
    exp_drain[0] = 32'h2001_1001;
    exp_drain[1] = 32'h2002_1002;
    exp_drain[2] = 32'h2003_1003;
    exp_drain[3] = 32'h4444_3333;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), ir, exp_drain[i]);
      pop_one();
    end
    check("drain_count", 32'(count), 32'd0);

    // streaming with the decoder always ready
    ir_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_valid = (k < 12);
      bus = 16'h5000 + 16'(k);
      @(posedge clk);
      #1;
      check("stream_cnt_le1", 32'(count <= 3'd1), 32'd1);
      if (ir_valid) got_q.push_back(ir);
    end
    wr_valid = 1'b0;
    ir_ready = 1'b0;
    check("stream_words", 32'(got_q.size()), 32'd6);
    for (int j = 0; j < 6; j++) begin
      if (j < got_q.size())
        check($sformatf("stream%0d", j), got_q[j],
              {16'h5000 + 16'(2*j+1), 16'h5000 + 16'(2*j)});
    end
    check("stream_fetch", 32'(fetch_address), 32'h0018);

    // flush in HIGH with count=2 and a simultaneous transfer and pop
    xfer(16'hA000); xfer(16'hA001); xfer(16'hA002); xfer(16'hA003); xfer(16'hA004);
    check("pre_flush_count", 32'(count), 32'd2);
    flush = 1'b1;
    flush_addr = 16'h0100;
    wr_valid = 1'b1;
    bus = 16'h7777;
    ir_ready = 1'b1;
    #1;
    check("flush_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_valid = 1'b0;
    ir_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_ir_valid", 32'(ir_valid), 32'd0);
    check("flush_fetch", 32'(fetch_address), 32'h0100);
    xfer(16'h8888);
    check("pf_low_count", 32'(count), 32'd0);
    check("pf_low_fetch", 32'(fetch_address), 32'h0101);
    xfer(16'h9999);
    check("pf_word", ir, 32'h9999_8888);
    pop_one();

    // fetch address wraps
    flush = 1'b1;
    flush_addr = 16'hFFFF;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("wrap0", 32'(fetch_address), 32'h0000_FFFF);
    xfer(16'hC001);
    check("wrap1", 32'(fetch_address), 32'h0000_0000);
    xfer(16'hC002);
    check("wrap2", 32'(fetch_address), 32'h0000_0001);
    check("wrap_word", ir, 32'hC002_C001);

    // asynchronous reset between edges, mid-assembly with count=3
    xfer(16'hD000); xfer(16'hD001); xfer(16'hD002); xfer(16'hD003); xfer(16'hD004);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_ir_valid", 32'(ir_valid), 32'd0);
    check("arst_fetch", 32'(fetch_address), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    check("arst_ir", ir, 32'h0);
    #1;
    reset = 1'b1;
    xfer(16'h1111);
    check("post_rst_low", 32'(count), 32'd0);
    xfer(16'h2222);
    check("post_rst_word", ir, 32'h2222_1111);
    check("post_rst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
